// File: rtl/tt_minterm_sweeper.sv
// tt_minterm_sweeper: walks every input vector of a combinational netlist,
// samples its single-bit output and streams the indices of the 1-vectors
// (minterms) out of a small FIFO over a valid/ready handshake.
// Optional feature macro: TT_SWEEPER_DONTCARE_EN adds dc_in/m_dc so that
// don't-care vectors are queued and tagged alongside the true minterms.
module tt_minterm_sweeper #(
    parameter int unsigned N_IN       = 14,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            f_in,
`ifdef TT_SWEEPER_DONTCARE_EN
    input  logic            dc_in,
    output logic            m_dc,
`endif
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N_IN-1:0] m_index,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   minterm_count
);

    localparam int unsigned VW = N_IN;
    localparam int unsigned CW = N_IN + 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OW = PW + 1;
`ifdef TT_SWEEPER_DONTCARE_EN
    localparam int unsigned EW = N_IN + 1;
`else
    localparam int unsigned EW = N_IN;
`endif
    localparam logic [VW-1:0] VEC_LAST = {VW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] vec_q, vec_d;
    logic [CW-1:0] mcnt_q, mcnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [OW-1:0] occ_q, occ_d;

    logic          full_c, empty_c, pop_c, hit_c, count_c;
    logic          accept_c, push_c, last_c;
    logic [EW-1:0] entry_c, head_c;

    // FIFO status; full is judged on the registered occupancy, before any pop
    assign full_c  = (occ_q == OW'(FIFO_DEPTH));
    assign empty_c = (occ_q == '0);
    assign pop_c   = !empty_c && m_ready;
    assign occ_d   = occ_q + OW'(push_c) - OW'(pop_c);

`ifdef TT_SWEEPER_DONTCARE_EN
    // Don't-cares are queued regardless of f_in but do not count as minterms
    assign hit_c   = f_in | dc_in;
    assign count_c = ~dc_in;
    assign entry_c = {dc_in, vec_q};
`else
    assign hit_c   = f_in;
    assign count_c = 1'b1;
    assign entry_c = vec_q;
`endif

    // A vector is consumed only while sweeping with room in the FIFO
    assign accept_c = (state_q == S_SWEEP) && !full_c;
    assign push_c   = accept_c && hit_c;
    assign last_c   = (vec_q == VEC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SWEEP;
            S_SWEEP: if (accept_c && last_c) state_d = S_DRAIN;
            S_DRAIN: if (occ_d == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: vector counter, minterm counter, status flags
    always_comb begin
        vec_d  = vec_q;
        mcnt_d = mcnt_q;
        case (state_q)
            S_IDLE: begin
                vec_d = '0;
                if (start) begin
                    mcnt_d = '0;
                end
            end
            S_SWEEP: begin
                if (accept_c && !last_c) begin
                    vec_d = vec_q + VW'(1);
                end
                if (push_c && count_c) begin
                    mcnt_d = mcnt_q + CW'(1);
                end
            end
            S_DRAIN: vec_d = vec_q;
            S_DONE:  vec_d = '0;
            default: vec_d = '0;
        endcase
        if (state_d == S_DONE) begin
            vec_d = '0;
        end
        busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            vec_q  <= '0;
            mcnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            vec_q  <= vec_d;
            mcnt_q <= mcnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Minterm FIFO storage and pointers; reset flushes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= entry_c;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            occ_q <= occ_d;
        end
    end

    assign head_c        = mem_q[rd_ptr_q];
    assign m_valid       = !empty_c;
    assign m_index       = head_c[VW-1:0];
`ifdef TT_SWEEPER_DONTCARE_EN
    assign m_dc          = head_c[EW-1];
`endif
    assign vec_out       = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign minterm_count = mcnt_q;

endmodule

// File: tb/tb_tt_minterm_sweeper.sv
// Directed bench for tt_minterm_sweeper at N_IN=4, FIFO_DEPTH=4.
module tb_tt_minterm_sweeper;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] vec_out;
    logic       f_in;
    logic       m_valid;
    logic       m_ready;
    logic [3:0] m_index;
    logic       busy;
    logic       done;
    logic [4:0] minterm_count;
`ifdef TT_SWEEPER_DONTCARE_EN
    logic       dc_in;
    logic       m_dc;
    bit         got_dc[$];
`endif

    int total = 0;
    int bad   = 0;
    int mode  = 0;

    // results gathered by run_sweep
    logic [3:0] got[$];
    int done_cnt, done_cyc, v15_cyc, v4_cnt, stab_bad, busy_after;
    bit valid_seen;

    tt_minterm_sweeper #(.N_IN(4), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .vec_out(vec_out),
        .f_in(f_in),
`ifdef TT_SWEEPER_DONTCARE_EN
        .dc_in(dc_in),
        .m_dc(m_dc),
`endif
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_index(m_index),
        .busy(busy),
        .done(done),
        .minterm_count(minterm_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Netlist-under-test models, selected by mode
    always_comb begin
        case (mode)
            1:       f_in = (vec_out == 4'd3) || (vec_out == 4'd9) || (vec_out == 4'd15);
            2:       f_in = 1'b1;
            3:       f_in = (vec_out == 4'd2) || (vec_out == 4'd5);
            4:       f_in = (vec_out == 4'd5);
            default: f_in = 1'b0;
        endcase
    end
`ifdef TT_SWEEPER_DONTCARE_EN
    always_comb begin
        dc_in = (mode == 4) && ((vec_out == 4'd5) || (vec_out == 4'd6));
    end
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then observe one cycle per iteration (cycle 1 = first after start)
    task automatic run_sweep(input int ready_on, input int s1, input int s2, input int s3,
                             input int max_cyc);
        logic [3:0] prev_idx;
        bit prev_stall;
        got.delete();
`ifdef TT_SWEEPER_DONTCARE_EN
        got_dc.delete();
`endif
        done_cnt = 0; done_cyc = -1; v15_cyc = -1; v4_cnt = 0;
        stab_bad = 0; busy_after = 0; valid_seen = 0;
        prev_stall = 0; prev_idx = '0;
        m_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            m_ready = (cyc >= ready_on);
            start   = (cyc == s1) || (cyc == s2) || (cyc == s3);
            if (prev_stall && (!m_valid || m_index !== prev_idx)) stab_bad++;
            if (m_valid) valid_seen = 1;
            if (m_valid && m_ready) begin
                got.push_back(m_index);
`ifdef TT_SWEEPER_DONTCARE_EN
                got_dc.push_back(m_dc);
`endif
            end
            if (vec_out == 4'd15 && v15_cyc < 0) v15_cyc = cyc;
            if (vec_out == 4'd4 && busy) v4_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc > done_cyc && busy) busy_after++;
            prev_stall = m_valid && !m_ready;
            prev_idx   = m_index;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            tick();
        end
        start = 1'b0;
        m_ready = 1'b0;
        total++;
        if (done_cyc < 0) begin
            bad++;
            $display("FAIL sweep_timeout: done not seen within %0d cycles", max_cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; m_ready = 1'b0; mode = 0;
        tick(); tick();
        reset = 1'b0;
        total++; if (vec_out !== 4'd0) begin bad++; $display("FAIL rst_vec: got %0d want 0", vec_out); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        total++; if (m_index !== 4'd0) begin bad++; $display("FAIL rst_index: got %0d want 0", m_index); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (minterm_count !== 5'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", minterm_count); end
    endtask

    task automatic test_sparse_stream;
        mode = 1;
        run_sweep(0, 0, 0, 0, 100);
        total++; if (got.size() != 3) begin bad++; $display("FAIL sparse_len: got %0d want 3", got.size()); end
        else begin
            total++; if (got[0] !== 4'd3)  begin bad++; $display("FAIL sparse_0: got %0d want 3", got[0]); end
            total++; if (got[1] !== 4'd9)  begin bad++; $display("FAIL sparse_1: got %0d want 9", got[1]); end
            total++; if (got[2] !== 4'd15) begin bad++; $display("FAIL sparse_2: got %0d want 15", got[2]); end
        end
        total++; if (minterm_count !== 5'd3) begin bad++; $display("FAIL sparse_count: got %0d want 3", minterm_count); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL sparse_done_cnt: got %0d want 1", done_cnt); end
        total++; if (v15_cyc != 16) begin bad++; $display("FAIL sparse_sweep_len: vec15 at %0d want 16", v15_cyc); end
        total++; if (done_cyc != 18) begin bad++; $display("FAIL sparse_done_cyc: got %0d want 18", done_cyc); end
    endtask

    task automatic test_backpressure;
        bit order_ok;
        mode = 2;
        run_sweep(10, 0, 0, 0, 100);
        total++; if (got.size() != 16) begin bad++; $display("FAIL bp_len: got %0d want 16", got.size()); end
        order_ok = (got.size() == 16);
        for (int i = 0; i < got.size() && i < 16; i++) begin
            if (got[i] !== 4'(i)) order_ok = 0;
        end
        total++; if (!order_ok) begin bad++; $display("FAIL bp_order: indices not 0..15 in order (len %0d)", got.size()); end
        total++; if (v4_cnt != 7) begin bad++; $display("FAIL bp_hold4: vec 4 held %0d cycles want 7", v4_cnt); end
        total++; if (stab_bad != 0) begin bad++; $display("FAIL bp_stable: %0d unstable stall cycles want 0", stab_bad); end
        total++; if (minterm_count !== 5'd16) begin bad++; $display("FAIL bp_count: got %0d want 16", minterm_count); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_no_minterms;
        int gap;
        mode = 0;
        run_sweep(0, 0, 0, 0, 100);
        gap = done_cyc - v15_cyc;
        total++; if (valid_seen) begin bad++; $display("FAIL none_valid: m_valid seen, want never"); end
        total++; if (minterm_count !== 5'd0) begin bad++; $display("FAIL none_count: got %0d want 0", minterm_count); end
        total++; if (v15_cyc < 0 || gap < 1 || gap > 2) begin bad++; $display("FAIL none_done_gap: got %0d want 1..2", gap); end
    endtask

    task automatic test_reset_mid_sweep;
        mode = 3; m_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && vec_out != 4'd7; i++) tick();
        total++; if (vec_out !== 4'd7) begin bad++; $display("FAIL mid_reach7: got %0d want 7", vec_out); end
        total++; if (m_valid !== 1'b1 || m_index !== 4'd2) begin bad++; $display("FAIL mid_queued: valid %b idx %0d want 1/2", m_valid, m_index); end
        reset = 1'b1;
        tick();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (vec_out !== 4'd0) begin bad++; $display("FAIL mid_vec: got %0d want 0", vec_out); end
        total++; if (minterm_count !== 5'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", minterm_count); end
        reset = 1'b0;
        mode = 1;
        run_sweep(0, 0, 0, 0, 100);
        total++; if (got.size() != 3 || got[0] !== 4'd3) begin bad++; $display("FAIL mid_restart: len %0d want 3 starting at 3", got.size()); end
        total++; if (done_cyc != 18) begin bad++; $display("FAIL mid_restart_done: got %0d want 18", done_cyc); end
    endtask

    task automatic test_start_ignored;
        mode = 1;
        // cycle 5 is SWEEP, 17 is DRAIN, 18 is DONE
        run_sweep(0, 5, 17, 18, 100);
        total++; if (got.size() != 3 || got[1] !== 4'd9) begin bad++; $display("FAIL ign_stream: len %0d want 3,9,15", got.size()); end
        total++; if (done_cyc != 18) begin bad++; $display("FAIL ign_done_cyc: got %0d want 18", done_cyc); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
        total++; if (busy_after != 0) begin bad++; $display("FAIL ign_restart: busy %0d cycles after done want 0", busy_after); end
    endtask

`ifdef TT_SWEEPER_DONTCARE_EN
    task automatic test_dontcare;
        mode = 4;
        run_sweep(0, 0, 0, 0, 100);
        total++; if (got.size() != 2) begin bad++; $display("FAIL dc_len: got %0d want 2", got.size()); end
        else begin
            total++; if (got[0] !== 4'd5 || got_dc[0] !== 1'b1) begin bad++; $display("FAIL dc_0: idx %0d dc %b want 5/1", got[0], got_dc[0]); end
            total++; if (got[1] !== 4'd6 || got_dc[1] !== 1'b1) begin bad++; $display("FAIL dc_1: idx %0d dc %b want 6/1", got[1], got_dc[1]); end
        end
        total++; if (minterm_count !== 5'd0) begin bad++; $display("FAIL dc_count: got %0d want 0", minterm_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_sparse_stream();
        test_backpressure();
        test_no_minterms();
        test_reset_mid_sweep();
        test_start_ignored();
`ifdef TT_SWEEPER_DONTCARE_EN
        test_dontcare();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
